cpu_oci_dct_packer: RTL and testbench

Parametrised data-capture-trace (DCT) packer for the Nios II on-chip instrumentation (OCI) block. Accepts single trace items from the OCI trace path and packs them into fixed-width multi-slot frames. Frames are buffered in a small show-ahead FIFO and handed to the trace sink over a valid/ready handshake. End of test is handled explicitly: `test_ending` flushes the partial frame, drains the FIFO, then asserts `test_has_ended`.

---
 rtl/cpu_oci_dct_packer.sv | 179 +++++++++++++++++
 tb/tb_cpu_oci_dct_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oci_dct_packer.sv
// rtl/cpu_oci_dct_packer.sv - OCI data-capture-trace item packer with frame FIFO (optional DCT_OVERFLOW_MARK_EN)
module cpu_oci_dct_packer #(
    parameter int ITEM_W     = 10,
    parameter int SLOTS      = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int FRAME_W   = SLOTS * ITEM_W,
    localparam int CNT_W     = $clog2(SLOTS + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [ITEM_W-1:0]  in_item,
    input  logic               flush,
    input  logic               test_ending,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_frame,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_lost,
    output logic [15:0]        overflow_cnt,
    output logic               test_has_ended
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   run_mode;
    logic   te_q;
    logic   te_rise;

    logic [FRAME_W-1:0] asm_data;
    logic [CNT_W-1:0]   asm_cnt;
    logic [FRAME_W-1:0] frame_next;
    logic [CNT_W-1:0]   count_next;
    logic               acc_item;
    logic               do_flush;
    logic               push_req;
    logic               push_ok;
    logic               pop;

    logic [FRAME_W-1:0] mem     [FIFO_DEPTH];
    logic [CNT_W-1:0]   cnt_mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      level;
    logic [PW-1:0]      level_next;
    logic               fifo_empty;
    logic               fifo_full;

    // ---------------- end-of-test state machine ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            te_q    <= test_ending;
        end
    end

    assign te_rise = test_ending && !te_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (te_rise) state_d = ST_DRAIN;
            ST_DRAIN: if (level_next == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        run_mode       = (state_q == ST_RUN);
        test_has_ended = (state_q == ST_DONE);
    end

    // ---------------- frame assembly ----------------
    assign acc_item   = run_mode && in_valid;
    assign do_flush   = run_mode && (flush || te_rise);
    assign count_next = asm_cnt + CNT_W'(acc_item);
    assign push_req   = (acc_item && (asm_cnt == CNT_W'(SLOTS - 1)))
                     || (do_flush && (count_next != '0));

    // Unused slots stay zero because the assembly register is cleared on every push.
    always_comb begin
        frame_next = asm_data;
        if (acc_item) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (asm_cnt == CNT_W'(k)) begin
                    frame_next[k*ITEM_W +: ITEM_W] = in_item;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            asm_data <= '0;
            asm_cnt  <= '0;
        end else if (push_req) begin
            asm_data <= '0;
            asm_cnt  <= '0;
        end else if (acc_item) begin
            asm_data <= frame_next;
            asm_cnt  <= count_next;
        end
    end

    // ---------------- show-ahead frame FIFO ----------------
    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop        = out_valid && out_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign level_next = level + PW'(push_ok) - PW'(pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]]     <= frame_next;
            cnt_mem[wr_ptr[AW-1:0]] <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_cnt <= '0;
        end else if (push_req && !push_ok && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_frame = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign out_count = out_valid ? cnt_mem[rd_ptr[AW-1:0]] : '0;

`ifdef DCT_OVERFLOW_MARK_EN
    // A drop arms the mark; the next frame that actually enters the FIFO carries it.
    logic lost_pending;
    logic lost_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lost_pending <= 1'b0;
        end else if (push_req && !push_ok) begin
            lost_pending <= 1'b1;
        end else if (push_ok) begin
            lost_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) lost_mem[wr_ptr[AW-1:0]] <= lost_pending;
    end

    assign out_lost = out_valid && lost_mem[rd_ptr[AW-1:0]];
`else
    assign out_lost = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// tb/tb_cpu_oci_dct_packer.sv - directed self-checking bench for cpu_oci_dct_packer
module tb_cpu_oci_dct_packer;

    localparam int ITEM_W  = 10;
    localparam int SLOTS   = 3;
    localparam int FRAME_W = 30;
    localparam int CNT_W   = 2;
`ifdef DCT_OVERFLOW_MARK_EN
    localparam logic LOST_EN = 1'b1;
`else
    localparam logic LOST_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [ITEM_W-1:0]  in_item;
    logic               flush;
    logic               test_ending;
    logic               out_valid;
    logic               out_ready;
    logic [FRAME_W-1:0] out_frame;
    logic [CNT_W-1:0]   out_count;
    logic               out_lost;
    logic [15:0]        overflow_cnt;
    logic               test_has_ended;

    int checks   = 0;
    int failures = 0;

    cpu_oci_dct_packer #(.ITEM_W(ITEM_W), .SLOTS(SLOTS), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_item        (in_item),
        .flush          (flush),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_frame      (out_frame),
        .out_count      (out_count),
        .out_lost       (out_lost),
        .overflow_cnt   (overflow_cnt),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] frame3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        return {2'b00, c, b, a};
    endfunction

    task automatic send_item(input logic [9:0] v);
        in_valid = 1'b1;
        in_item  = v;
        tick();
        in_valid = 1'b0;
        in_item  = '0;
    endtask

    task automatic send_frame(input logic [9:0] base);
        send_item(base);
        send_item(base + 10'd1);
        send_item(base + 10'd2);
    endtask

    task automatic expect_head(input string tag, input logic [9:0] base, input logic lost);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_frame"}, {2'b0, out_frame}, frame3(base, base + 10'd1, base + 10'd2));
        check({tag, "_count"}, {30'b0, out_count}, 32'd3);
        check({tag, "_lost"}, {31'b0, out_lost}, {31'b0, lost});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_item = '0; flush = 1'b0;
        test_ending = 1'b0; out_ready = 1'b0;
        do_reset();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_frame", {2'b0, out_frame}, 32'd0);
        check("rst_count", {30'b0, out_count}, 32'd0);
        check("rst_lost", {31'b0, out_lost}, 32'd0);
        check("rst_ovf", {16'b0, overflow_cnt}, 32'd0);
        check("rst_ended", {31'b0, test_has_ended}, 32'd0);

        // Single full frame, sink always ready: valid for exactly one cycle
        out_ready = 1'b1;
        send_item(10'h001);
        send_item(10'h002);
        check("t1_not_yet", {31'b0, out_valid}, 32'd0);
        send_item(10'h003);
        check("t1_valid", {31'b0, out_valid}, 32'd1);
        check("t1_frame", {2'b0, out_frame}, 32'h0030_0801);
        check("t1_count", {30'b0, out_count}, 32'd3);
        tick();
        check("t1_one_cycle", {31'b0, out_valid}, 32'd0);

        // Partial flush, then a flush on an empty assembly
        out_ready = 1'b0;
        send_item(10'h3FF);
        send_item(10'h155);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_valid", {31'b0, out_valid}, 32'd1);
        check("t2_frame", {2'b0, out_frame}, 32'h0005_57FF);
        check("t2_count", {30'b0, out_count}, 32'd2);
        tick();
        check("t2_hold", {2'b0, out_frame}, 32'h0005_57FF);
        out_ready = 1'b1; tick();
        check("t2_popped", {31'b0, out_valid}, 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("t2_empty_flush", {31'b0, out_valid}, 32'd0);

        // Overflow: 6 frames into a 4-deep FIFO
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) send_frame(10'(16 * (k + 1)));
        check("t3_ovf", {16'b0, overflow_cnt}, 32'd2);
        expect_head("t3_h0", 10'h010, 1'b0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send_frame(10'h100);
        check("t3_ovf_after", {16'b0, overflow_cnt}, 32'd2);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            expect_head("t3_hk", 10'(16 * (k + 1)), 1'b0);
            tick();
        end
        expect_head("t3_marked", 10'h100, LOST_EN);
        tick();
        check("t3_drained", {31'b0, out_valid}, 32'd0);

        // Full FIFO with push and pop in the same cycle
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(10'(10'h200 + 16 * k));
        send_item(10'h300);
        send_item(10'h301);
        in_valid = 1'b1; in_item = 10'h302; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("t5_ovf", {16'b0, overflow_cnt}, 32'd2);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            expect_head("t5_hk", 10'(10'h200 + 16 * k), 1'b0);
            tick();
        end
        expect_head("t5_last", 10'h300, 1'b0);
        tick();
        check("t5_drained", {31'b0, out_valid}, 32'd0);

        // Reset while full with asm_cnt == 2
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(10'(10'h040 + 16 * k));
        send_item(10'h0F0);
        send_item(10'h0F1);
        check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("t6_valid", {31'b0, out_valid}, 32'd0);
        check("t6_frame", {2'b0, out_frame}, 32'd0);
        check("t6_count", {30'b0, out_count}, 32'd0);
        check("t6_lost", {31'b0, out_lost}, 32'd0);
        check("t6_ovf", {16'b0, overflow_cnt}, 32'd0);
        check("t6_ended", {31'b0, test_has_ended}, 32'd0);
        out_ready = 1'b1;
        send_frame(10'h03A);
        expect_head("t6_new", 10'h03A, 1'b0);
        tick();
        check("t6_single", {31'b0, out_valid}, 32'd0);

        // End of test with a partial frame and two queued frames
        out_ready = 1'b0;
        send_frame(10'h050);
        send_frame(10'h060);
        send_item(10'h07F);
        test_ending = 1'b1; tick();
        in_valid = 1'b1; in_item = 10'h0AA; flush = 1'b1; tick();
        in_valid = 1'b0; flush = 1'b0;
        check("t4_ended_early", {31'b0, test_has_ended}, 32'd0);
        out_ready = 1'b1;
        expect_head("t4_f0", 10'h050, 1'b0); tick();
        expect_head("t4_f1", 10'h060, 1'b0); tick();
        check("t4_part_frame", {2'b0, out_frame}, 32'h0000_007F);
        check("t4_part_count", {30'b0, out_count}, 32'd1);
        check("t4_not_ended", {31'b0, test_has_ended}, 32'd0);
        tick();
        check("t4_empty", {31'b0, out_valid}, 32'd0);
        check("t4_ended", {31'b0, test_has_ended}, 32'd1);
        for (int k = 0; k < 3; k++) tick();
        check("t4_sticky", {31'b0, test_has_ended}, 32'd1);
        check("t4_no_extra", {31'b0, out_valid}, 32'd0);

        // End of test with nothing to drain: rises two cycles after the edge
        test_ending = 1'b0;
        do_reset();
        check("t7_rst_ended", {31'b0, test_has_ended}, 32'd0);
        test_ending = 1'b1; tick();
        check("t7_ended_n1", {31'b0, test_has_ended}, 32'd0);
        tick();
        check("t7_ended_n2", {31'b0, test_has_ended}, 32'd1);
        test_ending = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
